// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for the receive path and baud generator.
package uart_pkg;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // Baud-select encoding, shared with the baud generator's divider table.
    localparam logic [2:0] BAUD_9600   = 3'b000;
    localparam logic [2:0] BAUD_19200  = 3'b001;
    localparam logic [2:0] BAUD_38400  = 3'b010;
    localparam logic [2:0] BAUD_57600  = 3'b011;
    localparam logic [2:0] BAUD_115200 = 3'b100;
    localparam logic [2:0] BAUD_230400 = 3'b101;
    localparam logic [2:0] BAUD_460800 = 3'b110;
    localparam logic [2:0] BAUD_921600 = 3'b111;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - RX pin synchronizer with falling-edge (start-bit) detector.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rxd,
    output logic rxd_sync,
    output logic fall_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Flops reset to the idle level so leaving reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{UART_IDLE_LEVEL}};
            prev_q <= UART_IDLE_LEVEL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rxd_sync   = sync_q[SYNC_STAGES-1];
    assign fall_pulse = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receive engine: start detect, mid-bit sampling, valid/ready byte output.
// Parity checking and its ports are built only when UART_RX_PARITY_EN is defined.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_rxd,
    input  logic                 i_rx_strb,
    output logic                 o_rx_strb_en,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 o_overrun,
    input  logic                 i_parity_en,
    input  logic                 i_parity_odd,
    output logic                 o_parity_err
`else
    output logic                 o_overrun
`endif
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    rx_state_t            state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_q;
    logic                 rxd_sync;
    logic                 fall_pulse;
`ifdef UART_RX_PARITY_EN
    logic                 par_pend;
`endif

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd        (i_rxd),
        .rxd_sync   (rxd_sync),
        .fall_pulse (fall_pulse)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            o_rx_strb_en <= 1'b0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
            bit_cnt      <= '0;
            shift_q      <= '0;
`ifdef UART_RX_PARITY_EN
            par_pend     <= 1'b0;
            o_parity_err <= 1'b0;
`endif
        end else begin
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            o_parity_err <= 1'b0;
`endif
            // A completing byte in STOP overrides this clear.
            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (fall_pulse) begin
                        state        <= START;
                        o_rx_strb_en <= 1'b1;
                    end
                end
                START: begin
                    if (i_rx_strb) begin
                        if (!rxd_sync) begin
                            state   <= DATA;
                            bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            par_pend <= 1'b0;
`endif
                        end else begin
                            state        <= IDLE;
                            o_rx_strb_en <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (i_rx_strb) begin
                        shift_q <= {rxd_sync, shift_q[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= i_parity_en ? PARITY : STOP;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (i_rx_strb) begin
                        par_pend <= (^shift_q) ^ rxd_sync ^ i_parity_odd;
                        state    <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (i_rx_strb) begin
                        state        <= IDLE;
                        o_rx_strb_en <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        o_parity_err <= par_pend;
`endif
                        if (rxd_sync) begin
                            if (!o_valid || i_ready) begin
                                o_data  <= shift_q;
                                o_valid <= 1'b1;
                            end else begin
                                o_overrun <= 1'b1;
                            end
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    o_rx_strb_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receive engine downstream of the UART baud generator.
- Synchronizes the raw RX pin and detects start bits.
- Controls the generator's RX strobe enable, samples each bit on the mid-bit strobe, and presents received bytes on a valid/ready interface to the RX FIFO.
- Flags framing and overrun errors; parity checking is optional.

Parameters:
- DATA_BITS, 8, number of data bits per frame, sent LSB first.
- SYNC_STAGES, 2, number of flops in the RX pin synchronizer (minimum 2).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- i_rxd  input  1  asynchronous serial line; idle level is 1
- i_rx_strb  input  1  mid-bit sample strobe from the baud generator, one cycle wide
- o_rx_strb_en  output  1  enables the baud generator RX counter; low holds it at reload
- o_data  output  DATA_BITS  received byte; stable while o_valid=1
- o_valid  output  1  byte available
- i_ready  input  1  consumer accepts o_data when o_valid=1 and i_ready=1
- o_frame_err  output  1  one-cycle pulse; stop bit sampled as 0
- o_overrun  output  1  one-cycle pulse; a byte completed while the holding register was full

Behaviour:
- Synchronizer: SYNC_STAGES flops reset to 1, followed by a prev-flop that also resets to 1. A falling edge is sync=0 and prev=1.
- Reset: state=IDLE, o_rx_strb_en=0, o_data=0, o_valid=0, o_frame_err=0, o_overrun=0. Reset in mid-frame abandons the frame and does not pulse any error flag.
- State machine: IDLE, START, DATA, (PARITY), STOP. All outputs are registered.
- IDLE:
  - On a falling edge, go to START and set o_rx_strb_en=1 in the next cycle.
  - The generator then issues its first strobe at mid start bit.
- START:
  - On i_rx_strb with sync=0, go to DATA and clear the bit counter.
  - On i_rx_strb with sync=1 (glitch), go to IDLE and clear o_rx_strb_en. No flag is raised.
- DATA:
  - On each i_rx_strb, shift the sample in at the MSB with a right shift, then increment the bit counter.
  - After strobe DATA_BITS, go to PARITY if parity is enabled, otherwise STOP.
  - The bit counter is $clog2(DATA_BITS+1) wide and cannot wrap.
- STOP: on i_rx_strb, go to IDLE and clear o_rx_strb_en in the same registered update.
  - Sample=1: the byte is complete.
  - Sample=0: pulse o_frame_err and discard the byte.
- After a framing error (break), IDLE re-arms only on a fresh falling edge. A line held at 0 never re-triggers.
- i_rx_strb outside START/DATA/PARITY/STOP is ignored.
- Holding register, evaluated when a byte completes:
  - o_valid=0, or o_valid=1 and i_ready=1 in the same cycle: load o_data and set o_valid=1.
  - o_valid=1 and i_ready=0: keep the old byte, drop the new one, pulse o_overrun.
  - A handshake with no completing byte clears o_valid in the next cycle.
- Maximum throughput is one byte per frame time. No combinational path runs from i_ready to o_valid.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined, two extra ports exist:
  - i_parity_en  input  1  enables the parity bit
  - i_parity_odd  input  1  selects odd parity (1) or even parity (0)
- The PARITY state samples one bit after the data bits. A mismatch between the XOR of the data bits, the parity bit and i_parity_odd pulses o_parity_err (output, 1 bit, one cycle) at the STOP strobe.
- A byte with a parity error is still delivered if its stop bit is good. The flag is for the CSR only.
- When i_parity_en=0, PARITY is skipped.
- When not defined, these ports and the PARITY state do not exist, and DATA goes directly to STOP.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP)
  - UART_IDLE_LEVEL = 1'b1
  - baud-select encoding constants shared with the baud generator (3'b000 = 9600 … 3'b111 = 921600)
- Sub-module uart_rx_sync: the parameterized synchronizer plus falling-edge detector. Outputs are rxd_sync and fall_pulse.

Test Plan:
- CLK_FREQ=100 MHz, baud generator at 115200 (divider 868, bit period 869 cycles), send 0xA5 with 1 start, 8 data bits and 1 stop -> o_valid rises one cycle after the stop-bit strobe, o_data=0xA5, no error flags.
- Low glitch on i_rxd of 200 cycles in IDLE -> START sample is 1, return to IDLE, o_rx_strb_en falls, no o_valid, no flags.
- Frame 0x3C with stop bit forced to 0 -> one-cycle o_frame_err, o_valid stays 0; line held low 5 bit-times, then a good frame 0x81 -> 0x81 received, single error pulse only.
- i_ready=0, send 0x11 then 0x22 back-to-back -> o_data stays 0x11 with o_valid=1, one o_overrun pulse; raise i_ready on the completion cycle of a third byte 0x33 -> 0x33 loaded, o_valid stays 1, no overrun.
- rst_n asserted during DATA bit 4 of 0xFF, then released -> all outputs 0 on the next cycle, no flags; the next frame 0x5A is received correctly.
- With UART_RX_PARITY_EN, i_parity_en=1, i_parity_odd=0, send 0x07 with parity bit 0 -> o_parity_err pulses, o_data=0x07 delivered; send 0x07 with parity bit 1 -> no o_parity_err.
